// File: rtl/gate_tt_sequencer_if.sv
// Handshake and result bundle between the truth-table sequencer and its harness.
// The slave side is the sequencer; the master side drives start and the gate output.
interface gate_tt_sequencer_if #(
  parameter int N_IN = 2
);
  localparam int V = 1 << N_IN;

  logic              start;
  logic              y_in;
  logic [N_IN-1:0]   a;
  logic              busy;
  logic              done;
  logic              pass;
  logic [V-1:0]      captured;
  logic [V-1:0]      fail_mask;
  logic [N_IN:0]     err_count;

  modport master (
    output start, y_in,
    input  a, busy, done, pass, captured, fail_mask, err_count
  );

  modport slave (
    input  start, y_in,
    output a, busy, done, pass, captured, fail_mask, err_count
  );
endinterface

// File: rtl/gate_tt_sequencer.sv
// Exhaustive truth-table sweeper for a small combinational gate: applies every
// input vector in ascending order, samples y after a settle window, records failures.
module gate_tt_sequencer #(
  parameter int                    N_IN          = 2,
  parameter int                    SETTLE_CYCLES = 2,
  parameter logic [(1<<N_IN)-1:0]  EXPECTED      = 4'b1000
) (
  input logic               clk,
  input logic               rst,
  gate_tt_sequencer_if.slave bus
);
  localparam int V  = 1 << N_IN;
  localparam int CW = $clog2(SETTLE_CYCLES) + 1;
  localparam int VW = N_IN + 1;

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_e;

  state_e          state_q, state_d;
  logic [VW-1:0]   vec_q, vec_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            pass_q, pass_d;
  logic [V-1:0]    cap_q, cap_d;
  logic [V-1:0]    fm_q, fm_d;
  logic [N_IN:0]   ec_q, ec_d;

  logic [N_IN-1:0] vec_idx;
  logic            miss;

  assign vec_idx = vec_q[N_IN-1:0];
  assign miss    = bus.y_in ^ EXPECTED[vec_idx];

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = done_q;
    pass_d  = pass_q;
    cap_d   = cap_q;
    fm_d    = fm_q;
    ec_d    = ec_q;
    case (state_q)
      // DONE accepts a restart exactly like IDLE; results clear on the accepting edge
      IDLE, DONE: begin
        if (bus.start) begin
          state_d = SETTLE;
          vec_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          cap_d   = '0;
          fm_d    = '0;
          ec_d    = '0;
        end
      end
      SETTLE: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(SETTLE_CYCLES - 1)) state_d = SAMPLE;
      end
      SAMPLE: begin
        cap_d[vec_idx] = bus.y_in;
        fm_d[vec_idx]  = miss;
        if (miss) ec_d = ec_q + (N_IN+1)'(1);
        if (vec_q == VW'(V - 1)) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (fm_d == '0);
        end else begin
          vec_d   = vec_q + VW'(1);
          cnt_d   = '0;
          state_d = SETTLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      vec_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      cap_q   <= '0;
      fm_q    <= '0;
      ec_q    <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      cap_q   <= cap_d;
      fm_q    <= fm_d;
      ec_q    <= ec_d;
    end
  end

  assign bus.a         = vec_q[N_IN-1:0];
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.pass      = pass_q;
  assign bus.captured  = cap_q;
  assign bus.fail_mask = fm_q;
  assign bus.err_count = ec_q;
endmodule

// File: tb/tb_gate_tt_sequencer.sv
// Scoreboard bench for gate_tt_sequencer: two instances (default and fast OR config)
// driven by random gate truth tables, with y_in randomised outside the sample cycle.
module tb_gate_tt_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  gate_tt_sequencer_if #(.N_IN(2)) if0();
  gate_tt_sequencer_if #(.N_IN(2)) if1();

  gate_tt_sequencer u0 (.clk(clk), .rst(rst), .bus(if0));
  gate_tt_sequencer #(.N_IN(2), .SETTLE_CYCLES(1), .EXPECTED(4'b1110)) u1 (
    .clk(clk), .rst(rst), .bus(if1));

  logic [1:0] st = '0;
  logic [1:0] yv = '0;
  assign if0.start = st[0];
  assign if0.y_in  = yv[0];
  assign if1.start = st[1];
  assign if1.y_in  = yv[1];

  logic [1:0] a_w   [2];
  logic [3:0] cap_w [2];
  logic [3:0] fm_w  [2];
  logic [2:0] ec_w  [2];
  logic       busy_w[2];
  logic       done_w[2];
  logic       pass_w[2];
  assign a_w[0] = if0.a;         assign a_w[1] = if1.a;
  assign cap_w[0] = if0.captured; assign cap_w[1] = if1.captured;
  assign fm_w[0] = if0.fail_mask; assign fm_w[1] = if1.fail_mask;
  assign ec_w[0] = if0.err_count; assign ec_w[1] = if1.err_count;
  assign busy_w[0] = if0.busy;   assign busy_w[1] = if1.busy;
  assign done_w[0] = if0.done;   assign done_w[1] = if1.done;
  assign pass_w[0] = if0.pass;   assign pass_w[1] = if1.pass;

  typedef struct {
    int         d;
    logic [3:0] cap;
    logic [3:0] fm;
    logic [2:0] ec;
    logic       pass;
  } exp_t;
  exp_t sbq[$];

  int         SC  [2] = '{2, 1};
  logic [3:0] EXPV[2] = '{4'b1000, 4'b1110};

  // Reference: cycle position since the accepting edge; gate modelled as a lookup table
  bit         m_busy[2];
  bit         m_done[2];
  int         cyc[2];
  logic [3:0] gtbl[2];
  logic       done_prev[2];

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(string nm, int d, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d t=%0t: got %0h expected %0h", nm, d, $time, act, exp);
    end
  endtask

  always @(posedge clk) begin
    exp_t e;
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        m_busy[d] = 1'b0;
        m_done[d] = 1'b0;
        cyc[d]    = 0;
      end else if (st[d] && !m_busy[d]) begin
        e.d    = d;
        e.cap  = gtbl[d];
        e.fm   = gtbl[d] ^ EXPV[d];
        e.ec   = 3'($countones(e.fm));
        e.pass = (e.fm == 4'b0);
        sbq.push_back(e);
        m_busy[d] = 1'b1;
        m_done[d] = 1'b0;
        cyc[d]    = 0;
      end else if (m_busy[d]) begin
        cyc[d]++;
        if (cyc[d] == 4 * (SC[d] + 1)) begin
          m_busy[d] = 1'b0;
          m_done[d] = 1'b1;
        end
      end
    end
    if (rst) sbq.delete();
    #1;
    // Gate value is only guaranteed in the cycle before each sample edge; noise elsewhere
    for (int d = 0; d < 2; d++) begin
      if (m_busy[d] && ((cyc[d] + 1) % (SC[d] + 1)) == 0)
        yv[d] = gtbl[d][cyc[d] / (SC[d] + 1)];
      else
        yv[d] = 1'($urandom);
    end
  end

  always @(negedge clk) begin
    exp_t e;
    logic [1:0] ea;
    for (int d = 0; d < 2; d++) begin
      ea = m_busy[d] ? 2'(cyc[d] / (SC[d] + 1)) : (m_done[d] ? 2'd3 : 2'd0);
      chk("a", d, 32'(a_w[d]), 32'(ea));
      chk("busy", d, 32'(busy_w[d]), 32'(m_busy[d]));
      chk("done", d, 32'(done_w[d]), 32'(m_done[d]));
      if (!m_done[d]) chk("pass_low", d, 32'(pass_w[d]), 32'(0));
      if ((!m_busy[d] && !m_done[d]) || (m_busy[d] && cyc[d] < SC[d] + 1)) begin
        chk("cap_clr", d, 32'(cap_w[d]), 32'(0));
        chk("fm_clr", d, 32'(fm_w[d]), 32'(0));
        chk("ec_clr", d, 32'(ec_w[d]), 32'(0));
      end
      if (done_w[d] === 1'b1 && done_prev[d] !== 1'b1) begin
        if (sbq.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL sb_unexpected_done dut%0d t=%0t: got done with no pending sweep", d, $time);
        end else begin
          e = sbq.pop_front();
          chk("sb_dut", d, 32'(d), 32'(e.d));
          chk("sb_captured", d, 32'(cap_w[d]), 32'(e.cap));
          chk("sb_fail_mask", d, 32'(fm_w[d]), 32'(e.fm));
          chk("sb_err_count", d, 32'(ec_w[d]), 32'(e.ec));
          chk("sb_pass", d, 32'(pass_w[d]), 32'(e.pass));
        end
      end
      done_prev[d] = done_w[d];
    end
  end

  task automatic pulse(int d);
    @(posedge clk); #1 st[d] = 1'b1;
    @(posedge clk); #1 st[d] = 1'b0;
  endtask

  task automatic wait_done(int d);
    int n = 0;
    while (done_w[d] !== 1'b1 && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 60) begin
      n_cmp++;
      n_fail++;
      $display("FAIL done_timeout dut%0d t=%0t: got no done expected done within 60 cycles", d, $time);
    end
    repeat (2) @(posedge clk);
  endtask

  task automatic sweep(int d, logic [3:0] t);
    gtbl[d] = t;
    pulse(d);
    wait_done(d);
  endtask

  initial begin
    gtbl[0] = 4'b0;
    gtbl[1] = 4'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // correct AND, stuck-0, stuck-1, NAND
    sweep(0, 4'b1000);
    sweep(0, 4'b0000);
    sweep(0, 4'b1111);
    sweep(0, 4'b0111);

    // start mid-sweep is ignored; start in DONE restarts
    gtbl[0] = 4'b1000;
    pulse(0);
    repeat (4) @(posedge clk);
    pulse(0);
    wait_done(0);
    gtbl[0] = 4'($urandom);
    pulse(0);
    wait_done(0);

    // reset while vector 2 is settling aborts the sweep
    gtbl[0] = 4'($urandom);
    pulse(0);
    repeat (6) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    sweep(0, 4'($urandom));

    // short settle, OR expectation
    sweep(1, 4'b1110);

    for (int i = 0; i < 8; i++) begin
      sweep(0, 4'($urandom));
      sweep(1, 4'($urandom));
    end

    repeat (3) @(posedge clk);
    chk("sb_drained", 0, 32'(sbq.size()), 32'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
